multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequencer between the execute stage and the shared multdiv unit.
- Accepts one MULT/DIV request at a time and latches the operands and destination tag.
- Drives the unit's operand bus and issues a single-cycle ctrl_MULT/ctrl_DIV start pulse.
- Waits for data_resultRDY, with a timeout guard.
- Returns the result, exception and tag to writeback as a one-cycle pulse.
- Holds busy high so the pipeline stalls while the unit is in use, and handles pipeline flush safely.

Parameters:
TIMEOUT, 40, maximum WAIT cycles before the operation is forced to complete with an exception.
TAG_W, 5, width of the destination-register tag carried with the request.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  request present this cycle
in_is_mult  in  1  request is a multiply
in_is_div  in  1  request is a divide
in_opA  in  32  operand A
in_opB  in  32  operand B
in_tag  in  TAG_W  destination tag
flush  in  1  kill the in-flight/incoming operation
in_ready  out  1  high only in IDLE
busy  out  1  high when state != IDLE; the pipeline stall source
md_operandA  out  32  registered operand A to the multdiv unit
md_operandB  out  32  registered operand B to the multdiv unit
md_ctrl_MULT  out  1  one-cycle multiply start pulse
md_ctrl_DIV  out  1  one-cycle divide start pulse
md_result  in  32  multdiv data_result
md_exception  in  1  multdiv data_exception
md_resultRDY  in  1  multdiv data_resultRDY
out_valid  out  1  one-cycle completion pulse
out_result  out  32  registered result
out_exception  out  1  registered exception (unit exception or timeout)
out_timeout  out  1  registered; 1 when completion was caused by timeout
out_tag  out  TAG_W  registered tag of the completed op

Behaviour:
- States: IDLE, START, WAIT, DRAIN, DONE.
- Reset (synchronous, overrides everything): state=IDLE, counter=0, all registered outputs=0.
  - Thus md_ctrl_*=0, out_valid=0, busy=0, in_ready=1.
  - Reset mid-operation abandons the op with no pulse and no out_valid.
- Accept condition: state==IDLE & in_valid & (in_is_mult XOR in_is_div) & !flush.
  - On accept: latch opA/opB into md_operandA/B, latch the tag and op type; next state START.
  - Both or neither op bit set: request ignored, state stays IDLE, no error output.
  - flush in IDLE blocks acceptance.
- START (1 cycle): exactly one of md_ctrl_MULT/md_ctrl_DIV = 1 per the latched op; counter cleared.
  - md_resultRDY is ignored in this state (stale).
  - Next state WAIT.
  - flush in START: the pulse is still issued, since the unit must not be left half-started; next state DRAIN.
- WAIT: the counter increments each cycle.
  - md_resultRDY=1: capture md_result/md_exception into out_result/out_exception; out_timeout=0; next state DONE.
  - No RDY and counter==TIMEOUT-1: out_result=0, out_exception=1, out_timeout=1; next state DONE.
  - flush with no RDY: next state DRAIN.
  - flush in the same cycle as RDY: discard the result; next state IDLE.
- DRAIN: wait for md_resultRDY or timeout, with the counter continuing.
  - Either event leads to IDLE with no out_valid and output registers unchanged.
  - Purpose: no new start pulse is issued while the unit is mid-operation.
- DONE (1 cycle): out_valid=1 unless flush is high this cycle (flush suppresses it); next state IDLE.
  - out_result/exception/timeout/tag hold until the next completion.
- md_operandA/B stay stable from START through the end of WAIT/DRAIN.
- Latency, with accept at edge 0:
  - md_ctrl pulse in cycle 1.
  - If RDY is first seen in cycle k ≥ 2, out_valid is in cycle k+1.
  - The next accept is possible in cycle k+2.
- md_ctrl_MULT and md_ctrl_DIV are never high simultaneously and never high outside START.
- The counter width is ceil(log2(TIMEOUT))+1 and saturates without wrap.

Test Plan:
- Reset, then MULT accepted with opA=7, opB=6, tag=3; the model unit asserts RDY 32 cycles after the pulse with result 42 -> exactly one md_ctrl_MULT pulse in cycle 1; busy high cycles 1..34; out_valid in one cycle with out_result=42, out_tag=3, out_exception=0.
- DIV opA=100, opB=0; the unit returns exception=1 with RDY -> out_valid with out_exception=1, out_timeout=0; md_ctrl_DIV pulses once and md_ctrl_MULT never does.
- Unit never asserts RDY, TIMEOUT=40 -> out_valid 41 cycles after the pulse cycle with out_result=0, out_exception=1, out_timeout=1; the controller then returns to IDLE.
- flush during WAIT at cycle 10, RDY at cycle 33 -> no out_valid, busy held through DRAIN until RDY, in_ready=1 the cycle after; a back-to-back new request is then accepted normally.
- in_valid with in_is_mult=in_is_div=1, and separately in_valid with flush=1 -> neither accepted, no md_ctrl pulse, state stays IDLE.
- reset asserted during WAIT, then RDY pulse -> all outputs 0 the cycle after reset, the RDY is ignored, and no out_valid appears.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the shared multdiv unit: accepts one
// MULT/DIV request, pulses the unit, waits for the result and hands it to writeback.
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_is_mult,
  input  logic             in_is_div,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             in_ready,
  output logic             busy,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic             out_exception,
  output logic             out_timeout,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       dbg_state_o
);

  // Handshake: a request is taken in any cycle where in_valid and in_ready are
  // both high (and flush is low); out_valid is a one-cycle pulse with no back-pressure.

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_mult_q, is_mult_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      res_q, res_d;
  logic             exc_q, exc_d;
  logic             to_q, to_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             accept;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign accept      = (state_q == IDLE) & in_valid & (in_is_mult ^ in_is_div) & ~flush;
  assign timeout_hit = (cnt_q >= CNT_LAST);
  // Saturating increment; the exit compare is >= so saturation can never hide a timeout.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_mult_q <= 1'b0;
      tag_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      to_q      <= 1'b0;
      otag_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mult_q <= is_mult_d;
      tag_q     <= tag_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      to_q      <= to_d;
      otag_q    <= otag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mult_d = is_mult_q;
    tag_d     = tag_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    exc_d     = exc_q;
    to_d      = to_q;
    otag_d    = otag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d     = in_opA;
          opb_d     = in_opB;
          tag_d     = in_tag;
          is_mult_d = in_is_mult;
          state_d   = START;
        end
      end
      START: begin
        // The pulse goes out even when flushed so the unit is never left half-started.
        cnt_d   = '0;
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (md_resultRDY) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            res_d   = md_result;
            exc_d   = md_exception;
            to_d    = 1'b0;
            otag_d  = tag_q;
            state_d = DONE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if (timeout_hit) begin
          res_d   = '0;
          exc_d   = 1'b1;
          to_d    = 1'b1;
          otag_d  = tag_q;
          state_d = DONE;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (md_resultRDY || timeout_hit) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign md_ctrl_MULT  = (state_q == START) &  is_mult_q;
  assign md_ctrl_DIV   = (state_q == START) & ~is_mult_q;
  assign out_valid     = (state_q == DONE) & ~flush;
  assign md_operandA   = opa_q;
  assign md_operandB   = opb_q;
  assign out_result    = res_q;
  assign out_exception = exc_q;
  assign out_timeout   = to_q;
  assign out_tag       = otag_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int TAG_W   = 5;
  localparam int QW      = 32 + 1 + 1 + TAG_W;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_is_mult, in_is_div, flush;
  logic [31:0]      in_opA, in_opB;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready, busy, md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0]      md_operandA, md_operandB, md_result, out_result;
  logic             md_exception, md_resultRDY;
  logic             out_valid, out_exception, out_timeout;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_mult(in_is_mult),
    .in_is_div(in_is_div), .in_opA(in_opA), .in_opB(in_opB), .in_tag(in_tag),
    .flush(flush), .in_ready(in_ready), .busy(busy), .md_operandA(md_operandA),
    .md_operandB(md_operandB), .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .out_valid(out_valid), .out_result(out_result), .out_exception(out_exception),
    .out_timeout(out_timeout), .out_tag(out_tag), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the op by its age in cycles since accept (age 1 = pulse cycle,
  // age-2 = cycles spent waiting) rather than by controller state.
  bit               m_ok = 1'b0;
  logic             m_busy, m_done, m_flushed, m_mult;
  int               m_age;
  logic [31:0]      m_opa, m_opb, m_res;
  logic             m_exc, m_to;
  logic [TAG_W-1:0] m_tag, m_otag;
  logic [QW-1:0]    exp_q[$];

  always @(posedge clock) begin
    if (reset) begin
      m_ok <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_flushed <= 1'b0; m_mult <= 1'b0;
      m_age <= 0; m_opa <= '0; m_opb <= '0; m_res <= '0; m_exc <= 1'b0; m_to <= 1'b0;
      m_tag <= '0; m_otag <= '0;
    end else if (!m_busy) begin
      if (in_valid && (in_is_mult != in_is_div) && !flush) begin
        m_busy <= 1'b1; m_age <= 1; m_flushed <= 1'b0; m_done <= 1'b0;
        m_opa <= in_opA; m_opb <= in_opB; m_mult <= in_is_mult; m_tag <= in_tag;
      end
    end else if (m_done) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_age == 1) begin
      m_age <= 2; m_flushed <= flush;
    end else if (md_resultRDY) begin
      if (m_flushed || flush) m_busy <= 1'b0;
      else begin
        m_done <= 1'b1; m_res <= md_result; m_exc <= md_exception; m_to <= 1'b0;
        m_otag <= m_tag; exp_q.push_back({md_result, md_exception, 1'b0, m_tag});
      end
    end else if (m_flushed) begin
      if (m_age - 2 >= TIMEOUT - 1) m_busy <= 1'b0;
      else m_age <= m_age + 1;
    end else if (flush) begin
      m_flushed <= 1'b1; m_age <= m_age + 1;
    end else if (m_age - 2 == TIMEOUT - 1) begin
      m_done <= 1'b1; m_res <= '0; m_exc <= 1'b1; m_to <= 1'b1; m_otag <= m_tag;
      exp_q.push_back({32'h0, 1'b1, 1'b1, m_tag});
    end else begin
      m_age <= m_age + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [QW-1:0] exp_e;
  always @(negedge clock) begin
    if (m_ok) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("md_ctrl_MULT", {31'b0, md_ctrl_MULT}, {31'b0, m_busy && m_age == 1 && !m_done && m_mult});
      chk("md_ctrl_DIV", {31'b0, md_ctrl_DIV}, {31'b0, m_busy && m_age == 1 && !m_done && !m_mult});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_busy && m_done && !flush});
      chk("md_operandA", md_operandA, m_opa);
      chk("md_operandB", md_operandB, m_opb);
      chk("out_result", out_result, m_res);
      chk("out_exception", {31'b0, out_exception}, {31'b0, m_exc});
      chk("out_timeout", {31'b0, out_timeout}, {31'b0, m_to});
      chk("out_tag", {27'b0, out_tag}, {27'b0, m_otag});
      chk("pulse_exclusive", {31'b0, md_ctrl_MULT & md_ctrl_DIV}, 32'h0);
      if (m_busy && m_done) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'h0, 32'h1);
        end else begin
          exp_e = exp_q.pop_front();
          if (!flush) begin
            chk("sb_result", out_result, exp_e[QW-1 -: 32]);
            chk("sb_exception", {31'b0, out_exception}, {31'b0, exp_e[TAG_W+1]});
            chk("sb_timeout", {31'b0, out_timeout}, {31'b0, exp_e[TAG_W]});
            chk("sb_tag", {27'b0, out_tag}, {27'b0, exp_e[TAG_W-1:0]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int            o_ov, o_busy, o_mp, o_dp, o_mp_cyc, o_back;
  logic [31:0]   o_res;
  logic          o_exc, o_to, o_zero;
  logic [TAG_W-1:0] o_tag;

  task automatic drive_idle();
    in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0; flush = 1'b0;
    md_resultRDY = 1'b0; md_exception = 1'b0; reset = 1'b0;
  endtask

  // Cycle 0 presents the request; observations are taken at each negedge.
  task automatic run_op(input bit mult, input bit div, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, input int rdy_c, input logic [31:0] res,
                        input bit exc, input int flush_c, input int rst_c, input int ncyc);
    o_ov = -1; o_busy = 0; o_mp = 0; o_dp = 0; o_mp_cyc = -1; o_back = -1;
    o_res = '0; o_exc = 1'b0; o_to = 1'b0; o_tag = '0; o_zero = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      in_valid = (c == 0); in_is_mult = mult; in_is_div = div;
      in_opA = a; in_opB = b; in_tag = tg;
      flush = (c == flush_c); reset = (c == rst_c);
      md_resultRDY = (c == rdy_c);
      md_result = (c == rdy_c) ? res : $urandom;
      md_exception = (c == rdy_c) ? exc : 1'b0;
      @(negedge clock);
      if (c > 0) begin
        if (busy) o_busy++;
        if (md_ctrl_MULT) begin o_mp++; o_mp_cyc = c; end
        if (md_ctrl_DIV) o_dp++;
        if (out_valid) begin
          o_ov = c; o_res = out_result; o_exc = out_exception; o_to = out_timeout; o_tag = out_tag;
        end
        if (c >= 2 && in_ready && o_back < 0) o_back = c;
        if (c == rst_c + 1)
          o_zero = !busy && in_ready && !md_ctrl_MULT && !md_ctrl_DIV && !out_valid &&
                   md_operandA == 0 && md_operandB == 0 && out_result == 0 &&
                   !out_exception && !out_timeout && out_tag == 0;
      end
      @(posedge clock); #1;
    end
    drive_idle();
  endtask

  // ---------------- main sequence ----------------
  int rmode;
  initial begin
    drive_idle();
    reset = 1'b1; in_opA = '0; in_opB = '0; in_tag = '0; md_result = '0;
    @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_pulses", {30'b0, md_ctrl_MULT, md_ctrl_DIV}, 32'h0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // MULT 7*6, RDY 32 cycles after the pulse
    run_op(1, 0, 32'd7, 32'd6, 5'd3, 33, 32'd42, 0, -1, -1, 40);
    chk("t1_mult_pulses", o_mp, 1);
    chk("t1_mult_pulse_cycle", o_mp_cyc, 1);
    chk("t1_div_pulses", o_dp, 0);
    chk("t1_busy_cycles", o_busy, 34);
    chk("t1_out_valid_cycle", o_ov, 34);
    chk("t1_result", o_res, 32'd42);
    chk("t1_tag", {27'b0, o_tag}, 32'd3);
    chk("t1_exception", {31'b0, o_exc}, 32'h0);
    chk("t1_ready_again", o_back, 35);

    // DIV by zero with unit exception
    run_op(0, 1, 32'd100, 32'd0, 5'd9, 5, 32'hFFFF_FFFF, 1, -1, -1, 10);
    chk("t2_out_valid_cycle", o_ov, 6);
    chk("t2_exception", {31'b0, o_exc}, 32'h1);
    chk("t2_timeout", {31'b0, o_to}, 32'h0);
    chk("t2_div_pulses", o_dp, 1);
    chk("t2_mult_pulses", o_mp, 0);

    // No RDY: timeout
    run_op(1, 0, 32'd5, 32'd5, 5'd12, -1, 32'd0, 0, -1, -1, 50);
    chk("t3_out_valid_cycle", o_ov, 42);
    chk("t3_result", o_res, 32'h0);
    chk("t3_exception", {31'b0, o_exc}, 32'h1);
    chk("t3_timeout", {31'b0, o_to}, 32'h1);
    chk("t3_ready_again", o_back, 43);

    // Flush in WAIT at cycle 10, RDY at 33; then an immediate back-to-back request
    run_op(1, 0, 32'd11, 32'd13, 5'd20, 33, 32'd143, 0, 10, -1, 34);
    chk("t4_no_out_valid", o_ov, -1);
    chk("t4_busy_cycles", o_busy, 33);
    chk("t4_in_ready_next", {31'b0, in_ready}, 32'h1);
    run_op(0, 1, 32'd20, 32'd4, 5'd7, 3, 32'd5, 0, -1, -1, 8);
    chk("t5_out_valid_cycle", o_ov, 4);
    chk("t5_result", o_res, 32'd5);
    chk("t5_tag", {27'b0, o_tag}, 32'd7);

    // Illegal op encoding, then a request blocked by flush
    run_op(1, 1, 32'd1, 32'd2, 5'd1, 2, 32'd9, 0, -1, -1, 5);
    chk("t6_both_pulses", o_mp + o_dp, 0);
    chk("t6_both_busy", o_busy, 0);
    run_op(1, 0, 32'd1, 32'd2, 5'd1, 2, 32'd9, 0, 0, -1, 5);
    chk("t6_flush_pulses", o_mp + o_dp, 0);
    chk("t6_flush_busy", o_busy, 0);

    // Reset in WAIT, then a stale RDY
    run_op(1, 0, 32'h1234, 32'h5678, 5'h1f, 12, 32'hABCD, 0, -1, 10, 16);
    chk("t7_no_out_valid", o_ov, -1);
    chk("t7_busy_cycles", o_busy, 10);
    chk("t7_all_zero_after_reset", {31'b0, o_zero}, 32'h1);

    // Randomized run; RDY density varies so timeouts and flushes in every phase occur
    for (int i = 0; i < 3000; i++) begin
      rmode = (i / 500) % 3;
      in_valid = $urandom_range(0, 1);
      {in_is_mult, in_is_div} = 2'($urandom_range(0, 3));
      in_opA = $urandom; in_opB = $urandom; in_tag = TAG_W'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 299) == 0);
      case (rmode)
        0: md_resultRDY = ($urandom_range(0, 3) == 0);
        1: md_resultRDY = ($urandom_range(0, 29) == 0);
        default: md_resultRDY = 1'b0;
      endcase
      md_result = $urandom; md_exception = $urandom_range(0, 1);
      @(posedge clock); #1;
    end
    drive_idle();
    repeat (TIMEOUT + 5) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
